key_step_ctrl: RTL and testbench

Front-end for the LFSR step/load datapath on the board. Takes the raw step key and the load-select switch from the board I/O, synchronises and debounces them, and emits clean single-cycle `step_pulse` / `load_pulse` strobes in the `clk` domain. Holding the key auto-repeats steps. The downstream LFSR stage advances on `step_pulse` and reloads its seed on `load_pulse`, so it never has to use a switch as a clock.

---
 rtl/key_ctrl_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/key_step_ctrl.sv | 159 +++++++++++++++
 tb/tb_key_step_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// rtl/key_ctrl_pkg.sv - shared state encoding and default timing constants for the step key front-end
package key_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REPEAT,
        REL_DB
    } key_state_e;

    localparam int DEF_DB_CYCLES     = 1000;
    localparam int DEF_REPEAT_DELAY  = 50000;
    localparam int DEF_REPEAT_PERIOD = 10000;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous board input
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_step_ctrl.sv
// rtl/key_step_ctrl.sv - debounced step/load strobe generator with auto-repeat for the LFSR stage
module key_step_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_in,
    input  logic       mode_in,
    output logic       step_pulse,
    output logic       load_pulse,
    output logic       pressed,
    output logic       repeat_active,
    output logic [7:0] pulse_cnt
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DB_CYCLES);
    localparam int RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);
    localparam bit RPT_EN  = (REPEAT_DELAY > 0);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic key_s;
    logic mode_s;

    sync_2ff u_key_sync (
        .clk (clk),
        .rst (rst),
        .d_i (key_in),
        .q_o (key_s)
    );

    sync_2ff u_mode_sync (
        .clk (clk),
        .rst (rst),
        .d_i (mode_in),
        .q_o (mode_s)
    );

    key_state_e       state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             mode_l_q, mode_l_d;
    logic             step_q, step_d;
    logic             load_q, load_d;
    logic             pressed_q, pressed_d;
    logic             repeat_q, repeat_d;
    logic [7:0]       pulse_cnt_q, pulse_cnt_d;

    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rpt_cnt_d = rpt_cnt_q;
        mode_l_d  = mode_l_q;
        step_d    = 1'b0;
        load_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_s) begin
                    state_d  = PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            PRESS_DB: begin
                if (!key_s) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    // Mode is captured only here, so switch changes mid-press are ignored.
                    state_d   = HELD;
                    rpt_cnt_d = '0;
                    mode_l_d  = mode_s;
                    load_d    = mode_s;
                    step_d    = !mode_s;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!key_s) begin
                    state_d  = REL_DB;
                    db_cnt_d = '0;
                end else if (!mode_l_q && RPT_EN) begin
                    if (rpt_cnt_q == DELAY_LAST) begin
                        state_d   = REPEAT;
                        step_d    = 1'b1;
                        rpt_cnt_d = '0;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!key_s) begin
                    state_d  = REL_DB;
                    db_cnt_d = '0;
                end else if (rpt_cnt_q == PERIOD_LAST) begin
                    step_d    = 1'b1;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            REL_DB: begin
                // A bounce back to high restarts the repeat delay but never steps.
                if (key_s) begin
                    state_d   = HELD;
                    rpt_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        pressed_d   = (state_d == HELD) || (state_d == REPEAT) || (state_d == REL_DB);
        repeat_d    = (state_d == REPEAT);
        pulse_cnt_d = pulse_cnt_q + 8'(step_d | load_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            rpt_cnt_q   <= '0;
            mode_l_q    <= 1'b0;
            step_q      <= 1'b0;
            load_q      <= 1'b0;
            pressed_q   <= 1'b0;
            repeat_q    <= 1'b0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            rpt_cnt_q   <= rpt_cnt_d;
            mode_l_q    <= mode_l_d;
            step_q      <= step_d;
            load_q      <= load_d;
            pressed_q   <= pressed_d;
            repeat_q    <= repeat_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    assign step_pulse    = step_q;
    assign load_pulse    = load_q;
    assign pressed       = pressed_q;
    assign repeat_active = repeat_q;
    assign pulse_cnt     = pulse_cnt_q;

endmodule

// File: tb/tb_key_step_ctrl.sv
// tb/tb_key_step_ctrl.sv - self-checking bench for key_step_ctrl against a timestamp-based reference model
module tb_key_step_ctrl;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       mode_in;
    logic       step_pulse;
    logic       load_pulse;
    logic       pressed;
    logic       repeat_active;
    logic [7:0] pulse_cnt;

    int total = 0;
    int bad   = 0;

    key_step_ctrl #(
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .mode_in       (mode_in),
        .step_pulse    (step_pulse),
        .load_pulse    (load_pulse),
        .pressed       (pressed),
        .repeat_active (repeat_active),
        .pulse_cnt     (pulse_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phases with absolute edge timestamps instead of counters.
    int  cyc = 0;
    int  ph = 0;          // 0 idle, 1 press debounce, 2 held, 3 release debounce
    int  t0 = 0;
    int  t_next = -1;
    int  npulse = 0;
    bit  k1, k2, m1, m2, ks, ms;
    bit  m_mode, m_rep;
    bit  e_step, e_load;

    always @(posedge clk) begin
        cyc++;
        e_step = 0;
        e_load = 0;
        if (rst) begin
            {k1, k2, m1, m2} = 4'b0;
            ph = 0; m_mode = 0; m_rep = 0; npulse = 0; t_next = -1;
        end else begin
            ks = k2; ms = m2;
            k2 = k1; k1 = key_in;
            m2 = m1; m1 = mode_in;
            case (ph)
                0: if (ks) begin ph = 1; t0 = cyc; end
                1: begin
                    if (!ks) ph = 0;
                    else if (cyc - t0 == DB) begin
                        ph = 2; m_mode = ms; m_rep = 0;
                        if (ms) e_load = 1; else e_step = 1;
                        t_next = (!ms && RD > 0) ? cyc + RD : -1;
                    end
                end
                2: begin
                    if (!ks) begin ph = 3; t0 = cyc; m_rep = 0; end
                    else if (cyc == t_next) begin e_step = 1; m_rep = 1; t_next = cyc + RP; end
                end
                default: begin
                    if (ks) begin
                        ph = 2; m_rep = 0;
                        t_next = (!m_mode && RD > 0) ? cyc + RD : -1;
                    end else if (cyc - t0 == DB) ph = 0;
                end
            endcase
            if (e_step || e_load) npulse++;
        end
    end

    always @(negedge clk) begin
        logic [11:0] act, exp;
        if (cyc > 0) begin
            act = {step_pulse, load_pulse, pressed, repeat_active, pulse_cnt};
            exp = {e_step, e_load, (ph == 2 || ph == 3), m_rep, 8'(npulse % 256)};
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model_cmp cyc=%0d act step/load/pr/rep/cnt=%b/%b/%b/%b/%0d exp=%b/%b/%b/%b/%0d",
                         cyc, act[11], act[10], act[9], act[8], act[7:0],
                         exp[11], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
    end

    // Pulse recording relative to the first edge of a directed sequence.
    int base = 0;
    int st_q[$];
    int ld_q[$];
    int rep_first = -1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (step_pulse) st_q.push_back(cyc - base);
        if (load_pulse) ld_q.push_back(cyc - base);
        if (repeat_active && rep_first < 0) rep_first = cyc - base;
    endtask

    task automatic start_rec();
        base = cyc + 1;
        st_q.delete();
        ld_q.delete();
        rep_first = -1;
    endtask

    task automatic hold(input bit k, input int n);
        key_in = k;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Key held from edge 0, reset sampled at edge rst_edge only.
    task automatic reset_press(input int rst_edge, input string name);
        do_reset();
        start_rec();
        key_in = 1'b1;
        repeat (rst_edge) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hold(1, 14);
        hold(0, 14);
        chk({name, "_npulse"}, st_q.size(), 1);
        if (st_q.size() == 1) chk({name, "_edge"}, st_q[0], rst_edge + 1 + DB + 2);
        chk({name, "_cnt"}, pulse_cnt, 1);
    endtask

    initial begin
        int c0, n;
        int exp_held[6];
        exp_held = '{6, 16, 19, 22, 25, 28};
        rst = 1'b1; key_in = 1'b0; mode_in = 1'b0;
        repeat (3) tick();
        chk("reset_cnt", pulse_cnt, 0);
        chk("reset_pressed", pressed, 0);
        chk("reset_pulses", {step_pulse, load_pulse}, 0);
        rst = 1'b0;
        tick();

        // Clean short press
        c0 = pulse_cnt;
        start_rec();
        hold(1, 12);
        hold(0, 14);
        chk("clean_nstep", st_q.size(), 1);
        if (st_q.size() == 1) chk("clean_edge", st_q[0], 6);
        chk("clean_nload", ld_q.size(), 0);
        chk("clean_cnt", pulse_cnt, c0 + 1);

        // Press bounce: last rise at edge 5
        start_rec();
        hold(1, 1); hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 1); hold(1, 1);
        hold(1, 8);
        hold(0, 14);
        chk("bounce_nstep", st_q.size(), 1);
        if (st_q.size() == 1) chk("bounce_edge", st_q[0], 11);

        // Held key with auto-repeat
        start_rec();
        hold(1, 30);
        hold(0, 14);
        n = 0;
        foreach (st_q[i]) if (st_q[i] < 30) n++;
        chk("held_nstep_lt30", n, 6);
        for (int i = 0; i < 6 && i < st_q.size(); i++) chk("held_edge", st_q[i], exp_held[i]);
        chk("held_rep_first", rep_first, 16);

        // Load press, mode toggled while held, bouncy release
        c0 = pulse_cnt;
        mode_in = 1'b1;
        start_rec();
        hold(1, 20);
        mode_in = 1'b0;
        hold(1, 10);
        mode_in = 1'b1;
        hold(1, 10);
        mode_in = 1'b0;
        hold(0, 1); hold(1, 1); hold(0, 14);
        chk("load_nload", ld_q.size(), 1);
        if (ld_q.size() == 1) chk("load_edge", ld_q[0], 6);
        chk("load_nstep", st_q.size(), 0);
        chk("load_cnt", pulse_cnt, (c0 + 1) % 256);

        // Reset mid-press, and reset coinciding with the pulse condition
        reset_press(5, "rst_mid");
        reset_press(6, "rst_coinc");

        // Randomized bouncy presses, mode changes and occasional resets
        for (int i = 0; i < 60; i++) begin
            mode_in = 1'($urandom_range(0, 1));
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) hold(1'($urandom_range(0, 1)), 1);
            hold(1, $urandom_range(1, 40));
            if ($urandom_range(0, 3) == 0) mode_in = ~mode_in;
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) hold(1'($urandom_range(0, 1)), 1);
            hold(0, $urandom_range(1, 12));
            if ($urandom_range(0, 15) == 0) do_reset();
        end
        hold(0, 12);

        // Counter wrap
        mode_in = 1'b0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            hold(1, 6);
            hold(0, 10);
            if (i == 254) chk("wrap_cnt_255", pulse_cnt, 255);
        end
        chk("wrap_cnt_0", pulse_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
